uart_prog_loader: RTL and testbench
===================================

# uart_prog_loader

Upstream feeder for `cpu_core` program memory: receives a Brainfuck program as a UART byte stream and writes it to consecutive program addresses from 0. It zero-pads the rest of memory up to `PROG_LEN` and checks bracket balance. It asserts `loaded` only for a complete, balanced program; `cpu_core` uses `loaded` to take over the program-memory address port.

## Interface
- `PROG_ADDR_WIDTH`, 14: program address width.
- `PROG_LEN`, 16383: number of program locations written (0..PROG_LEN-1).
- `CLK_HZ`, 12000000: clock frequency.
- `BAUD`, 115200: UART rate, 8N1, LSB first.
- `clk`  in  1  system clock, all logic on rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `rx`  in  1  UART line, asynchronous, idle high.
- `load_req`  in  1  level/pulse; starts a new load.
- `prog_we`  out  1  one-cycle program-memory write strobe.
- `prog_addr`  out  PROG_ADDR_WIDTH  write address.
- `prog_wr`  out  8  write data.
- `loaded`  out  1  program valid; memory owned by CPU.
- `busy`  out  1  receiving or padding.
- `bracket_err`  out  1  sticky unbalanced-bracket flag.
- `prog_count`  out  PROG_ADDR_WIDTH  bytes stored, excluding padding.

## Operation
- **Reset values:** all outputs are 0. State is L_IDLE.
- **L_IDLE:**
  - Received bytes are discarded.
  - On `load_req`: clear `loaded`, `bracket_err`, address, depth and `prog_count`; go to L_RECV.
- **L_RECV:** each valid received byte is handled in priority order.
  - Byte 0x00 or 0x04 is the terminator: it is not stored; go to L_PAD.
  - Otherwise write the byte at the current address, then increment the address and `prog_count`.
  - If the address reaches `PROG_LEN`, go to L_CHECK. Later bytes are ignored until the next `load_req`.
- **Bracket tracking (PROG_ADDR_WIDTH-bit depth counter):**
  - `[` (0x5B) increments the depth.
  - `]` (0x5D) at depth 0 sets `bracket_err`, still stores the byte, and leaves depth at 0.
  - `]` at nonzero depth decrements the depth.
- **L_PAD:** write 0x00 at each address from the current one to `PROG_LEN-1`, one per cycle; then go to L_CHECK.
- **L_CHECK:**
  - If depth ≠ 0, set `bracket_err`.
  - If `bracket_err` is 0: set `loaded`, go to L_DONE.
  - If `bracket_err` is 1: go to L_ERR with `loaded` held at 0.
- **L_DONE / L_ERR:** wait for `load_req`, which restarts as from L_IDLE.
- **`load_req` during L_RECV or L_PAD:** abort and restart at address 0 with all counters cleared.
- **Bus ownership:** `prog_we` is never asserted while `loaded` = 1. The top level gates `load_req` with `!executing`.
- **UART receiver:**
  - 2-flop synchronizer on `rx`; divisor is `CLK_HZ/BAUD`, truncated.
  - Falling edge starts a frame. The line is re-checked at half a bit; if high, it is a false start and is ignored.
  - Data bits are sampled at bit centres.
  - A stop bit sampled low is a framing error: the byte is dropped with no write and no count change.
- `busy` = 1 in L_RECV and L_PAD.

## Timing
- `prog_we`, `prog_addr` and `prog_wr` are registered and valid in the same cycle.
- Write latency is 1 cycle after the stop-bit centre sample.
- Padding takes `PROG_LEN - prog_count` cycles. `loaded` rises 1 cycle after the last pad write; L_CHECK takes 1 cycle.
- If the program fills memory with no terminator, `loaded` rises 1 cycle after the write to `PROG_LEN-1`.
- `load_req` is sampled every cycle. Its effect (`loaded` falls, counters clear) is visible on the next cycle.
- Asynchronous reset mid-load: outputs return to 0 immediately and memory contents are undefined.

## Configuration
- **`LOADER_FILTER_EN` defined:** only the eight command characters `><+-.,[]` are stored. All other non-terminator bytes (comments, whitespace) are discarded without changing the address or count.
- **`LOADER_FILTER_EN` undefined:** every non-terminator byte is stored as received.

## Structure
- **Shared package `bf_pkg`:**
  - Opcode constants `OP_INC_PTR`, `OP_DEC_PTR`, `OP_INC`, `OP_DEC`, `OP_OUT`, `OP_IN`, `OP_JZ`, `OP_JNZ` (also used by `cpu_core`).
  - Terminator constants `TERM_NUL`, `TERM_EOT`.
  - Loader state enum `loader_state_t`.
- **Sub-module `uart_rx`:** inputs `clk`, `resetn`, `rx`; outputs `data[7:0]`, one-cycle `valid`, one-cycle `frame_err`; parameters `CLK_HZ`, `BAUD`.

## Test plan
Bench settings: `CLK_HZ`=12e6, `BAUD`=1e6, `PROG_LEN`=32.
- **Normal load:** `load_req`, send "+[-]." then 0x00 -> writes 2B,5B,2D,5D,2E at addresses 0-4; 0x00 at 5-31; `prog_count`=5; `loaded`=1 one cycle after the address-31 write; `bracket_err`=0.
- **Filter:** with `LOADER_FILTER_EN`, send "+ a\n+" then 0x04 -> only 2B at addresses 0 and 1; `prog_count`=2. Without the macro -> `prog_count`=5.
- **Unbalanced brackets:** send "[[]" then 0x00 -> state L_ERR, `bracket_err`=1, `loaded`=0. Send "]" then 0x00 -> `bracket_err` set on the `]`.
- **Overflow:** send 40 '+' with no terminator -> 32 writes, `loaded`=1 after address 31, remaining 8 bytes ignored, `prog_count`=32.
- **Bad frames:** stop bit driven low on byte 2 -> that byte is not written and the next byte lands at address 1. A 0.3-bit low glitch -> no byte.
- **Abort:** `load_req` mid-padding -> `loaded`=0, address restarts at 0. Asserting `resetn`=0 mid-receive -> all outputs 0 in the same cycle.

Source files
------------

// File: rtl/bf_pkg.sv
// bf_pkg: Brainfuck opcodes, loader terminators and state types shared by loader and cpu_core
package bf_pkg;
  localparam logic [7:0] OP_INC_PTR = 8'h3E;
  localparam logic [7:0] OP_DEC_PTR = 8'h3C;
  localparam logic [7:0] OP_INC     = 8'h2B;
  localparam logic [7:0] OP_DEC     = 8'h2D;
  localparam logic [7:0] OP_OUT     = 8'h2E;
  localparam logic [7:0] OP_IN      = 8'h2C;
  localparam logic [7:0] OP_JZ      = 8'h5B;
  localparam logic [7:0] OP_JNZ     = 8'h5D;
  localparam logic [7:0] TERM_NUL   = 8'h00;
  localparam logic [7:0] TERM_EOT   = 8'h04;

  typedef enum logic [2:0] {L_IDLE, L_RECV, L_PAD, L_CHECK, L_DONE, L_ERR} loader_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  function automatic logic is_term(input logic [7:0] b);
    return b == TERM_NUL || b == TERM_EOT;
  endfunction

  function automatic logic is_cmd(input logic [7:0] b);
    return b inside {OP_INC_PTR, OP_DEC_PTR, OP_INC, OP_DEC, OP_OUT, OP_IN, OP_JZ, OP_JNZ};
  endfunction
endpackage

// File: rtl/uart_rx.sv
// uart_rx: 8N1 LSB-first receiver with false-start rejection; valid/frame_err pulse on the stop-bit centre sample
module uart_rx
  import bf_pkg::*;
#(
  parameter int CLK_HZ = 12000000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err
);
  localparam int DIV  = CLK_HZ / BAUD;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);

  rx_state_t st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0] bidx, bidx_n;
  logic [7:0] sh, sh_n;
  logic [2:0] sr;
  logic rx_s, rx_p, stop_hit;

  assign rx_s = sr[1];
  assign rx_p = sr[2];
  assign stop_hit = st == R_STOP && cnt == CW'(DIV - 1);
  assign data = sh;
  assign valid = stop_hit && rx_s;
  assign frame_err = stop_hit && !rx_s;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sr   <= 3'b111;
      st   <= R_IDLE;
      cnt  <= '0;
      bidx <= '0;
      sh   <= '0;
    end else begin
      sr   <= {sr[1:0], rx};
      st   <= st_n;
      cnt  <= cnt_n;
      bidx <= bidx_n;
      sh   <= sh_n;
    end
  end

  always_comb begin
    st_n   = st;
    cnt_n  = cnt + 1'b1;
    bidx_n = bidx;
    sh_n   = sh;
    case (st)
      R_IDLE: begin
        cnt_n = '0;
        st_n  = (rx_p && !rx_s) ? R_START : R_IDLE;
      end
      R_START: if (cnt == CW'(HALF - 1)) begin
        cnt_n  = '0;
        bidx_n = '0;
        st_n   = rx_s ? R_IDLE : R_DATA;
      end
      R_DATA: if (cnt == CW'(DIV - 1)) begin
        cnt_n  = '0;
        sh_n   = {rx_s, sh[7:1]};
        bidx_n = bidx + 1'b1;
        st_n   = (bidx == 3'd7) ? R_STOP : R_DATA;
      end
      default: if (stop_hit) begin
        cnt_n = '0;
        st_n  = R_IDLE;
      end
    endcase
  end
endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: UART-fed program-memory loader with zero padding and bracket check; `LOADER_FILTER_EN keeps only BF commands
module uart_prog_loader
  import bf_pkg::*;
#(
  parameter int PROG_ADDR_WIDTH = 14,
  parameter int PROG_LEN        = 16383,
  parameter int CLK_HZ          = 12000000,
  parameter int BAUD            = 115200
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       rx,
  input  logic                       load_req,
  output logic                       prog_we,
  output logic [PROG_ADDR_WIDTH-1:0] prog_addr,
  output logic [7:0]                 prog_wr,
  output logic                       loaded,
  output logic                       busy,
  output logic                       bracket_err,
  output logic [PROG_ADDR_WIDTH-1:0] prog_count
);
  localparam logic [PROG_ADDR_WIDTH-1:0] LAST = PROG_ADDR_WIDTH'(PROG_LEN - 1);

  loader_state_t state, state_n;
  logic [PROG_ADDR_WIDTH-1:0] addr, addr_n, depth, depth_n, cnt_n, pa_n;
  logic [7:0] rx_data, wr_n;
  logic rx_valid, rx_ferr, keep, err_n, loaded_n, we_n;

  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clk      (clk),
    .resetn   (resetn),
    .rx       (rx),
    .data     (rx_data),
    .valid    (rx_valid),
    .frame_err(rx_ferr)
  );

`ifdef LOADER_FILTER_EN
  assign keep = is_cmd(rx_data);
`else
  assign keep = 1'b1;
`endif

  assign busy = state == L_RECV || state == L_PAD;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state       <= L_IDLE;
      addr        <= '0;
      depth       <= '0;
      prog_count  <= '0;
      bracket_err <= 1'b0;
      loaded      <= 1'b0;
      prog_we     <= 1'b0;
      prog_addr   <= '0;
      prog_wr     <= '0;
    end else begin
      state       <= state_n;
      addr        <= addr_n;
      depth       <= depth_n;
      prog_count  <= cnt_n;
      bracket_err <= err_n;
      loaded      <= loaded_n;
      prog_we     <= we_n;
      prog_addr   <= pa_n;
      prog_wr     <= wr_n;
    end
  end

  // load_req wins in every state, so it doubles as the abort path
  always_comb begin
    state_n  = state;
    addr_n   = addr;
    depth_n  = depth;
    cnt_n    = prog_count;
    err_n    = bracket_err;
    loaded_n = loaded;
    we_n     = 1'b0;
    pa_n     = prog_addr;
    wr_n     = prog_wr;
    if (load_req) begin
      state_n  = L_RECV;
      addr_n   = '0;
      depth_n  = '0;
      cnt_n    = '0;
      err_n    = 1'b0;
      loaded_n = 1'b0;
    end else begin
      case (state)
        L_RECV: if (rx_valid && !rx_ferr) begin
          if (is_term(rx_data)) begin
            state_n = L_PAD;
          end else if (keep) begin
            we_n    = 1'b1;
            pa_n    = addr;
            wr_n    = rx_data;
            addr_n  = addr + 1'b1;
            cnt_n   = prog_count + 1'b1;
            depth_n = (rx_data == OP_JZ) ? depth + 1'b1 :
                      (rx_data == OP_JNZ && depth != '0) ? depth - 1'b1 : depth;
            err_n   = bracket_err || (rx_data == OP_JNZ && depth == '0);
            state_n = (addr == LAST) ? L_CHECK : L_RECV;
          end
        end
        L_PAD: begin
          we_n    = 1'b1;
          pa_n    = addr;
          wr_n    = 8'h00;
          addr_n  = addr + 1'b1;
          state_n = (addr == LAST) ? L_CHECK : L_PAD;
        end
        L_CHECK: begin
          err_n    = bracket_err || depth != '0;
          loaded_n = !err_n;
          state_n  = err_n ? L_ERR : L_DONE;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: randomized and directed loads checked by a write scoreboard against a byte-stream model
module tb_uart_prog_loader;
  localparam int AW = 14;
  localparam int PLEN = 32;
  localparam int BIT_CYC = 12;

  typedef logic [7:0] bq_t[$];

  logic clk = 0, resetn = 0, rx = 1, load_req = 0;
  logic prog_we, loaded, busy, bracket_err;
  logic [AW-1:0] prog_addr, prog_count;
  logic [7:0] prog_wr;

  int tests = 0, fails = 0;
  int exp_q[$];
  bit sb_off = 0, chk_loaded = 0, exp_loaded = 0;
  bit mid_ok[64], mid_err[64];
  int mid_cnt[64];

  uart_prog_loader #(.PROG_ADDR_WIDTH(AW), .PROG_LEN(PLEN), .CLK_HZ(12000000), .BAUD(1000000)) dut (
    .clk(clk), .resetn(resetn), .rx(rx), .load_req(load_req), .prog_we(prog_we),
    .prog_addr(prog_addr), .prog_wr(prog_wr), .loaded(loaded), .busy(busy),
    .bracket_err(bracket_err), .prog_count(prog_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input int a, input int e);
    tests++;
    if (a != e) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", n, a, a, e, e);
    end
  endtask

  function automatic bit is_cmd(input logic [7:0] b);
    return b inside {">", "<", "+", "-", ".", ",", "[", "]"};
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  // scoreboard monitor: every write must match the next expected {addr,data}
  always @(negedge clk) begin
    if (resetn) begin
      if (chk_loaded) begin
        chk("loaded_after_last_write", loaded, exp_loaded);
        chk_loaded = 0;
      end
      if (prog_we && loaded) chk("we_while_loaded", 1, 0);
      if (prog_we && !sb_off) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_write_addr", prog_addr, -1);
        end else begin
          int e;
          e = exp_q.pop_front();
          chk("write_addr", prog_addr, e >> 8);
          chk("write_data", prog_wr, e & 8'hFF);
        end
        if (prog_addr == AW'(PLEN - 1)) chk_loaded = 1;
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    @(negedge clk) rx = 0;
    repeat (BIT_CYC) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CYC) @(negedge clk);
    end
    rx = !bad_stop;
    repeat (BIT_CYC) @(negedge clk);
    rx = 1;
  endtask

  task automatic pulse_load();
    @(negedge clk) load_req = 1;
    @(negedge clk) load_req = 0;
    chk("req_loaded_clr", loaded, 0);
    chk("req_cnt_clr", prog_count, 0);
    chk("req_err_clr", bracket_err, 0);
    chk("req_busy", busy, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", n < 600, 1);
    repeat (3) @(negedge clk);
  endtask

  // model: walk the byte stream, decide what gets stored, then pad
  task automatic do_load(input bq_t bytes, input int bad, input bit glitch);
    int a = 0, depth = 0;
    bit err = 0, full = 0, term = 0;
    foreach (bytes[i]) begin
      mid_ok[i] = 0;
      if (full || term) continue;
      if (i != bad) begin
        logic [7:0] b = bytes[i];
        if (b == 8'h00 || b == 8'h04) begin
          term = 1;
          continue;
        end
`ifdef LOADER_FILTER_EN
        if (!is_cmd(b)) begin
          mid_ok[i] = 1; mid_cnt[i] = a; mid_err[i] = err;
          continue;
        end
`endif
        exp_q.push_back((a << 8) | b);
        if (b == "[") depth++;
        else if (b == "]") begin
          if (depth == 0) err = 1;
          else depth--;
        end
        a++;
        if (a == PLEN) full = 1;
      end
      if (!full) begin
        mid_ok[i] = 1; mid_cnt[i] = a; mid_err[i] = err;
      end
    end
    if (term) for (int p = a; p < PLEN; p++) exp_q.push_back(p << 8);
    exp_loaded = !(err || depth != 0);
    pulse_load();
    if (glitch) begin
      @(negedge clk) rx = 0;
      repeat (4) @(negedge clk);
      rx = 1;
      repeat (30) @(negedge clk);
      chk("glitch_cnt", prog_count, 0);
    end
    foreach (bytes[i]) begin
      send_byte(bytes[i], i == bad);
      repeat (3) @(negedge clk);
      if (mid_ok[i]) begin
        chk("mid_count", prog_count, mid_cnt[i]);
        chk("mid_err", bracket_err, mid_err[i]);
      end
    end
    wait_idle();
    chk("final_loaded", loaded, exp_loaded);
    chk("final_err", bracket_err, !exp_loaded);
    chk("final_count", prog_count, a);
    chk("leftover_writes", exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] pool[11] = '{8'h2B, 8'h2D, 8'h3C, 8'h3E, 8'h2E, 8'h2C, 8'h5B, 8'h5D, 8'h61, 8'h20, 8'h0A};
    bq_t q;
    int n;
    repeat (3) @(negedge clk);
    chk("rst_we", prog_we, 0);
    chk("rst_addr", prog_addr, 0);
    chk("rst_wr", prog_wr, 0);
    chk("rst_loaded", loaded, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", bracket_err, 0);
    chk("rst_count", prog_count, 0);
    resetn = 1;
    repeat (5) @(negedge clk);

    q = str2q("+[-]."); q.push_back(8'h00); do_load(q, -1, 0);
    q = str2q("+ a\n+"); q.push_back(8'h04); do_load(q, -1, 0);
    q = str2q("[[]"); q.push_back(8'h00); do_load(q, -1, 0);
    q = str2q("]"); q.push_back(8'h00); do_load(q, -1, 0);
    q = {}; for (int i = 0; i < 40; i++) q.push_back("+"); do_load(q, -1, 0);
    q = str2q("+-."); q.push_back(8'h00); do_load(q, 1, 0);
    q = str2q("><"); q.push_back(8'h04); do_load(q, -1, 1);
    for (int k = 0; k < 6; k++) begin
      q = {};
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) q.push_back(pool[$urandom_range(0, 10)]);
      q.push_back($urandom_range(0, 1) ? 8'h04 : 8'h00);
      do_load(q, -1, 0);
    end

    // abort mid-padding, then a clean load must start again at address 0
    sb_off = 1;
    pulse_load();
    send_byte("+", 0);
    send_byte(8'h00, 0);
    n = 0;
    while (!(prog_we && prog_addr == AW'(10)) && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("pad_reached_timeout", n < 400, 1);
    pulse_load();
    repeat (40) @(negedge clk);
    chk("abort_no_loaded", loaded, 0);
    chk("abort_busy", busy, 1);
    chk_loaded = 0;
    sb_off = 0;
    q = str2q("+."); q.push_back(8'h00); do_load(q, -1, 0);

    // async reset in the middle of a byte
    sb_off = 1;
    pulse_load();
    send_byte("+", 0);
    repeat (5) @(negedge clk);
    chk("pre_rst_count", prog_count, 1);
    rx = 0;
    repeat (20) @(negedge clk);
    #2 resetn = 0;
    #1;
    chk("arst_we", prog_we, 0);
    chk("arst_addr", prog_addr, 0);
    chk("arst_wr", prog_wr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_count", prog_count, 0);
    chk("arst_loaded", loaded, 0);
    @(negedge clk) rx = 1;
    repeat (3) @(negedge clk);
    resetn = 1;
    exp_q.delete();
    chk_loaded = 0;
    sb_off = 0;
    repeat (30) @(negedge clk);
    q = str2q("[+]"); q.push_back(8'h00); do_load(q, -1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
